// File: rtl/onchip_mem_arbiter.sv
// Round-robin write/read arbiter and sequencer for the shared on-chip memory; read response WAIT_CYC+2 cycles after handshake, no response backpressure.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module onchip_mem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_req_valid,
  output logic                       wr_req_ready,
  input  logic [DATA_W-1:0]          wr_req_data,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  output logic                       rd_rsp_valid,
  output logic [DATA_W-1:0]          rd_rsp_data,
  output logic                       mem_wr_en,
  output logic                       mem_rd_en,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out,
  output logic                       mem_multi_cycle_mode,
  output logic [1:0]                 mem_cycle_count,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] word_count
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]                perf_wr_grants,
  output logic [15:0]                perf_rd_grants,
  output logic [15:0]                perf_stall_cycles
`endif
);

  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [1:0]       WAIT_LAST = 2'(WAIT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RSP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          wait_q, wait_d;
  logic                last_wr_q, last_wr_d;
  logic                wr_elig, rd_elig, grant_wr, grant_rd;

  always_comb begin
    wr_elig  = wr_req_valid && (count_q < FULL);
    rd_elig  = rd_req_valid && (count_q != '0);
    // On a tie the side that did not win last time goes next.
    grant_wr = (state_q == ST_IDLE) && wr_elig && (!rd_elig || !last_wr_q);
    grant_rd = (state_q == ST_IDLE) && rd_elig && !grant_wr;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    wait_d    = wait_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          data_d    = wr_req_data;
          count_d   = count_q + 1'b1;
          last_wr_d = 1'b1;
          state_d   = ST_WR;
        end else if (grant_rd) begin
          count_d   = count_q - 1'b1;
          last_wr_d = 1'b0;
          wait_d    = 2'd0;
          state_d   = ST_RD;
        end
      end
      ST_WR:  state_d = ST_IDLE;
      ST_RD: begin
        if (wait_q == WAIT_LAST) state_d = ST_RSP;
        else                     wait_d  = wait_q + 2'd1;
      end
      ST_RSP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      data_q    <= '0;
      wait_q    <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign wr_req_ready         = grant_wr;
  assign rd_req_ready         = grant_rd;
  assign mem_wr_en            = (state_q == ST_WR);
  assign mem_rd_en            = (state_q == ST_RD);
  assign rd_rsp_valid         = (state_q == ST_RSP);
  assign rd_rsp_data          = (state_q == ST_RSP) ? mem_data_out : '0;
  assign mem_data_in          = data_q;
  assign mem_multi_cycle_mode = (WAIT_CYC != 0);
  assign mem_cycle_count      = WAIT_LAST;
  assign busy                 = (state_q != ST_IDLE);
  assign word_count           = count_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_wr_q, perf_rd_q, perf_stall_q;
  logic        stall;

  assign stall = (wr_req_valid && !wr_req_ready) || (rd_req_valid && !rd_req_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_wr_q    <= '0;
      perf_rd_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_wr && (perf_wr_q != 16'hFFFF))   perf_wr_q    <= perf_wr_q + 16'd1;
      if (grant_rd && (perf_rd_q != 16'hFFFF))   perf_rd_q    <= perf_rd_q + 16'd1;
      if (stall && (perf_stall_q != 16'hFFFF))   perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_wr_grants    = perf_wr_q;
  assign perf_rd_grants    = perf_rd_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
